// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO.
// MULT/MULTU/DIV/DIVU run iteratively over 33 cycles; MTHI/MTLO write in one cycle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s, signed_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     sum_s, rem_sh_s;
  logic               geq_s;
  logic [2*WIDTH-1:0] prod_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    cond_neg = en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign accept_s = Start && ((Func == F_MULT) || (Func == F_MULTU) ||
                              (Func == F_DIV)  || (Func == F_DIVU));
  assign signed_s = (Func == F_MULT) || (Func == F_DIV);
  assign a_neg_s  = signed_s && Rdata1[WIDTH-1];
  assign b_neg_s  = signed_s && Rdata2[WIDTH-1];
  assign a_mag_s  = cond_neg(Rdata1, a_neg_s);
  assign b_mag_s  = cond_neg(Rdata2, b_neg_s);

  // One shift-add step (multiply) and one restoring step (divide) per CALC cycle.
  assign sum_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign geq_s    = rem_sh_s >= {1'b0, opb_q};
  assign prod_s   = neg_lo_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_s) state_d = S_CALC; else state_d = S_IDLE;
      S_CALC:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX; else state_d = S_CALC;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          is_div_d = Func[1];
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (Func[1]) begin
            // Quotient sign is suppressed on divide-by-zero so Lo stays all ones.
            opb_d    = b_mag_s;
            acc_d    = {{WIDTH{1'b0}}, a_mag_s};
            neg_lo_d = (a_neg_s ^ b_neg_s) && (Rdata2 != '0);
            neg_hi_d = a_neg_s;
          end else begin
            opb_d    = a_mag_s;
            acc_d    = {{WIDTH{1'b0}}, b_mag_s};
            neg_lo_d = a_neg_s ^ b_neg_s;
            neg_hi_d = a_neg_s ^ b_neg_s;
          end
        end else if (Start && (Func == F_MTHI)) begin
          hi_d = Rdata1;
        end else if (Start && (Func == F_MTLO)) begin
          lo_d = Rdata1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CALC: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (is_div_q) begin
          if (geq_s) acc_d = {rem_sh_s[WIDTH-1:0] - opb_q, acc_q[WIDTH-2:0], 1'b1};
          else       acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {sum_s, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        if (is_div_q) begin
          hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
          lo_d = cond_neg(acc_q[WIDTH-1:0], neg_lo_q);
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with hand-computed HI/LO results.
module tb_ex_muldiv_unit;

  logic        CLK, RST, Start, Busy, Done;
  logic [5:0]  Func;
  logic [31:0] Rdata1, Rdata2, Hi, Lo;

  int checks   = 0;
  int failures = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Func(Func),
    .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one iterative op; optionally inject an MTLO while busy.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit inject);
    int n;
    logic [31:0] lo_before;
    lo_before = Lo;
    Start = 1'b1; Func = f; Rdata1 = a; Rdata2 = b;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    Rdata1 = 32'hA5A5_5A5A;
    Rdata2 = 32'h0000_0003;
    n = 0;
    while (Busy && n < 40) begin
      if (inject && n == 5) begin
        Start = 1'b1; Func = 6'h13; Rdata1 = 32'h0000_DEAD;
      end else if (inject && n == 6) begin
        Start = 1'b0;
        check_eq({tag, "_lo_hold"}, {32'h0, Lo}, {32'h0, lo_before});
      end
      n++;
      @(negedge CLK);
    end
    check_eq({tag, "_busy_cycles"}, 64'(n), 64'd33);
    check_eq({tag, "_done"}, {63'h0, Done}, 64'd1);
    check_eq({tag, "_hilo"}, {Hi, Lo}, {exp_hi, exp_lo});
    @(negedge CLK);
    check_eq({tag, "_done_fall"}, {63'h0, Done}, 64'd0);
  endtask

  initial begin
    int dones;
    RST = 1'b1; Start = 1'b0; Func = 6'h00; Rdata1 = '0; Rdata2 = '0;
    repeat (2) @(negedge CLK);
    check_eq("reset_state", {Busy, Done, 30'h0, Hi ^ Lo}, 64'd0);
    check_eq("reset_hilo", {Hi, Lo}, 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    run_op("mult_neg", 6'h18, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_m1", 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op("div_neg", 6'h1A, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2", 6'h1B, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0);
    run_op("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("div_rem", 6'h1A, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_zero", 6'h1B, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
    run_op("div_zero_neg", 6'h1A, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);

    // MTHI while idle: single-cycle write, no Busy/Done.
    Start = 1'b1; Func = 6'h11; Rdata1 = 32'h1234_5678;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    check_eq("mthi_hilo", {Hi, Lo}, {32'h1234_5678, 32'hFFFF_FFFF});
    check_eq("mthi_flags", {62'h0, Busy, Done}, 64'd0);
    Start = 1'b1; Func = 6'h13; Rdata1 = 32'h0BAD_F00D;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    check_eq("mtlo_hilo", {Hi, Lo}, {32'h1234_5678, 32'h0BAD_F00D});

    run_op("divu_ignore_mtlo", 6'h1B, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b1);

    // Async reset in the middle of a multiply.
    Start = 1'b1; Func = 6'h18; Rdata1 = 32'd3; Rdata2 = 32'd4;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    check_eq("pre_rst_busy", {63'h0, Busy}, 64'd1);
    #2 RST = 1'b1;
    #1;
    check_eq("async_rst", {Busy, Done, 30'h0, 32'h0}, 64'd0);
    check_eq("async_rst_hilo", {Hi, Lo}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done || Busy) dones++;
    end
    check_eq("no_done_after_rst", 64'(dones), 64'd0);

    run_op("multu_6_7", 6'h19, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
